conv1_ctrl: RTL and testbench

Frame-level sequencer for the first convolution stage. Accepts a raster-order pixel stream for one `WIDTH`×`HEIGHT` image, drives line-buffer writes and the per-window valid strobe into the convolution engine, honours the max-pool back-pressure signal, and counts engine results until the frame is complete. It sits between the pixel source, the window buffer and conv engine, and the max-pool stage.

---
 rtl/conv1_ctrl.sv | 155 +++++++++++++++
 tb/tb_conv1_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv1_ctrl.sv
// conv1_ctrl: frame sequencer for conv stage 1 (pixel intake, window strobe, result counting).
// Define CONV1_CTRL_TIMEOUT_EN to add the drain watchdog and sticky err.
module conv1_ctrl #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int FILTER_SIZE = 7,
    parameter int TIMEOUT     = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic                      buf_wr_en,
    output logic                      win_valid,
    input  logic                      maxpool_ready,
    input  logic                      valid_out_calc,
    output logic                      out_valid,
    output logic [$clog2(HEIGHT)-1:0] out_row,
    output logic [$clog2(WIDTH)-1:0]  out_col,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int RW    = $clog2(HEIGHT);
    localparam int CW    = $clog2(WIDTH);
    localparam int OW    = WIDTH - FILTER_SIZE + 1;
    localparam int OH    = HEIGHT - FILTER_SIZE + 1;
    localparam int TOTAL = OW * OH;
    localparam int NW    = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_WIN   = CW'(FILTER_SIZE - 1);
    localparam logic [CW-1:0] OCOL_LAST = CW'(OW - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_WIN   = RW'(FILTER_SIZE - 1);
    localparam logic [NW-1:0] TOT       = NW'(TOTAL);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d, pr_q, pr_d, orow_q, orow_d;
    logic [CW-1:0] col_q, col_d, pc_q, pc_d, ocol_q, ocol_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          win_q, win_d, ov_q, ov_d;
    logic          accept, res, qual, wd_trip;

    assign pix_ready = (state_q == S_STREAM) && maxpool_ready;
    assign accept    = pix_valid && pix_ready;
    assign buf_wr_en = accept;
    assign busy      = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done      = state_q == S_DONE;
    assign res       = valid_out_calc && busy;
    assign qual      = accept && (row_q >= ROW_WIN) && (col_q >= COL_WIN);
    assign win_valid = win_q;
    assign out_valid = ov_q;
    assign out_row   = orow_q;
    assign out_col   = ocol_q;
    // A pending window survives stalls; a fresh one replaces a consumed one in the same cycle.
    assign win_d     = qual || (win_q && !maxpool_ready);
    assign ov_d      = res;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pr_d    = pr_q;
        pc_d    = pc_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE && start) begin
            state_d = S_STREAM;
            row_d   = '0;
            col_d   = '0;
            pr_d    = '0;
            pc_d    = '0;
            orow_d  = '0;
            ocol_d  = '0;
            cnt_d   = '0;
        end
        if (accept) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
            row_d = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;
            if (row_q == ROW_LAST && col_q == COL_LAST)
                state_d = S_DRAIN;
        end
        if (res) begin
            cnt_d  = cnt_q + 1'b1;
            orow_d = pr_q;
            ocol_d = pc_q;
            pc_d   = (pc_q == OCOL_LAST) ? '0 : pc_q + 1'b1;
            pr_d   = (pc_q == OCOL_LAST) ? pr_q + 1'b1 : pr_q;
        end
        if (state_q == S_DRAIN && cnt_q == TOT)
            state_d = S_DONE;
        if (state_q == S_DONE)
            state_d = S_IDLE;
        if (wd_trip)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pr_q    <= '0;
            pc_q    <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            cnt_q   <= '0;
            win_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pr_q    <= pr_d;
            pc_q    <= pc_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            ov_q    <= ov_d;
        end
    end

`ifdef CONV1_CTRL_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    assign wd_trip = (state_q == S_DRAIN) && !valid_out_calc && (wd_q == WD_LAST);
    assign wd_d    = ((state_q == S_DRAIN) && !valid_out_calc && !wd_trip) ? wd_q + 1'b1 : '0;
    assign err_d   = err_q || wd_trip;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`else
    assign wd_trip = 1'b0;
    // Without the watchdog err is a constant 0 for every legal TIMEOUT.
    assign err     = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_conv1_ctrl.sv
// tb_conv1_ctrl: scoreboard bench for conv1_ctrl with a fixed-latency engine model.
module tb_conv1_ctrl;
    localparam int W = 28, H = 28, K = 7, TO = 64, LAT = 6;
    localparam int OW = W - K + 1, OH = H - K + 1, TOTAL = OW * OH, NPIX = W * H;
    localparam int RW = $clog2(H), CW = $clog2(W);

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_valid = 1'b0;
    logic maxpool_ready = 1'b0, valid_out_calc = 1'b0;
    logic pix_ready, buf_wr_en, win_valid, out_valid, busy, done, err;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    int total = 0, bad = 0;
    int acc_cnt, hs_cnt, ov_cnt, done_cnt, res_sent, first_win, since_voc, first_err;
    bit seen_win, rnd_mp, withhold, poke_voc, stream_m, chk_ready;
    logic [LAT-1:0] pipe;
    logic [RW+CW-1:0] sb[$];
    logic [RW+CW-1:0] last_out;

    always #5 clk = ~clk;

    conv1_ctrl #(.WIDTH(W), .HEIGHT(H), .FILTER_SIZE(K), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .buf_wr_en(buf_wr_en), .win_valid(win_valid),
        .maxpool_ready(maxpool_ready), .valid_out_calc(valid_out_calc),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done), .err(err)
    );

    task automatic clear_stats();
        acc_cnt = 0; hs_cnt = 0; ov_cnt = 0; done_cnt = 0; res_sent = 0;
        first_win = -1; since_voc = 0; first_err = -1; seen_win = 0;
        stream_m = 0; pipe = '0; last_out = '1; sb.delete();
    endtask

    // One clock: drive at negedge, sample 1 time unit later, record what the next edge consumes.
    task automatic cyc(input bit st);
        bit real_voc, hs;
        logic [RW+CW-1:0] e;
        @(negedge clk);
        start = st;
        maxpool_ready = rnd_mp ? ($urandom_range(0, 3) != 0) : 1'b1;
        pix_valid = rnd_mp ? ($urandom_range(0, 5) != 0) : 1'b1;
        real_voc = pipe[LAT-1] && !(withhold && res_sent == TOTAL - 1);
        if (real_voc) res_sent++;
        valid_out_calc = real_voc || poke_voc;
        #1;
        if (err && first_err < 0) first_err = since_voc;
        since_voc = real_voc ? 0 : since_voc + 1;
        if (out_valid) begin
            total++;
            ov_cnt++;
            last_out = {out_row, out_col};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL out_valid_unexpected: got (%0d,%0d) want no result", out_row, out_col);
            end else begin
                e = sb.pop_front();
                if ({out_row, out_col} !== e) begin
                    bad++;
                    $display("FAIL out_coord #%0d: got (%0d,%0d) want (%0d,%0d)",
                             ov_cnt, out_row, out_col, e[RW+CW-1:CW], e[CW-1:0]);
                end
            end
        end
        if (done) done_cnt++;
        if (win_valid && !seen_win) begin seen_win = 1; first_win = acc_cnt; end
        if (chk_ready) begin
            total++;
            if (pix_ready !== (stream_m && maxpool_ready)) begin
                bad++;
                $display("FAIL pix_ready: got %b want %b", pix_ready, stream_m && maxpool_ready);
            end
        end
        if (buf_wr_en) begin
            acc_cnt++;
            if (acc_cnt == NPIX) stream_m = 0;
        end
        if (st && !busy && !done) stream_m = 1;
        hs = win_valid && maxpool_ready;
        if (hs) begin
            sb.push_back({RW'(hs_cnt / OW), CW'(hs_cnt % OW)});
            hs_cnt++;
        end
        pipe = {pipe[LAT-2:0], hs};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({pix_ready, buf_wr_en, win_valid, out_valid, busy, done, err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0", {pix_ready, buf_wr_en, win_valid, out_valid, busy, done, err});
        end
        total++;
        if ({out_row, out_col} !== '0) begin
            bad++;
            $display("FAIL reset_coords: got (%0d,%0d) want (0,0)", out_row, out_col);
        end
        rst_n = 1'b1;
        clear_stats();
        chk_ready = 1;
        repeat (3) cyc(1'b0);
        total++;
        if ({busy, done, err, win_valid} !== 4'b0 || acc_cnt != 0) begin
            bad++;
            $display("FAIL idle_no_start: got flags %b acc %0d want 0", {busy, done, err, win_valid}, acc_cnt);
        end
    endtask

    task automatic test_frame(input bit rnd, input bit poke, input string tag);
        int n;
        logic [RW+CW-1:0] exp_last;
        clear_stats();
        rnd_mp = rnd;
        exp_last = {RW'(OH - 1), CW'(OW - 1)};
        cyc(1'b1);
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            cyc(poke && ((acc_cnt == 100) || (acc_cnt == NPIX && busy)));
            n++;
        end
        repeat (10) cyc(1'b0);
        total++;
        if (n >= 20000) begin bad++; $display("FAIL %s_timeout: got no done within %0d cycles", tag, n); end
        total++;
        if (acc_cnt != NPIX) begin bad++; $display("FAIL %s_writes: got %0d want %0d", tag, acc_cnt, NPIX); end
        total++;
        if (hs_cnt != TOTAL) begin bad++; $display("FAIL %s_windows: got %0d want %0d", tag, hs_cnt, TOTAL); end
        total++;
        if (ov_cnt != TOTAL) begin bad++; $display("FAIL %s_results: got %0d want %0d", tag, ov_cnt, TOTAL); end
        total++;
        if (first_win != (K - 1) * W + K) begin
            bad++; $display("FAIL %s_first_win: got %0d want %0d", tag, first_win, (K - 1) * W + K);
        end
        total++;
        if (last_out !== exp_last) begin
            bad++; $display("FAIL %s_last_out: got %h want %h", tag, last_out, exp_last);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL %s_done: got %0d want 1", tag, done_cnt); end
        total++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_end: got pending %0d busy %b want 0 0", tag, sb.size(), busy);
        end
        if (poke) begin
            poke_voc = 1;
            repeat (5) cyc(1'b0);
            poke_voc = 0;
            cyc(1'b0);
            total++;
            if (ov_cnt != TOTAL || {out_row, out_col} !== exp_last || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_voc: got results %0d coord (%0d,%0d) busy %b want %0d (%0d,%0d) 0",
                         ov_cnt, out_row, out_col, busy, TOTAL, OH - 1, OW - 1);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        clear_stats();
        rnd_mp = 0;
        cyc(1'b1);
        n = 0;
        while (acc_cnt < 300 && n < 2000) begin cyc(1'b0); n++; end
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        valid_out_calc = 1'b0;
        #1;
        total++;
        if ({pix_ready, buf_wr_en, win_valid, out_valid, busy, done, err} !== 7'b0 || {out_row, out_col} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got flags %b coord (%0d,%0d) want all 0",
                     {pix_ready, buf_wr_en, win_valid, out_valid, busy, done, err}, out_row, out_col);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_frame(1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_timeout();
        int n;
        clear_stats();
        rnd_mp = 0;
        withhold = 1;
        cyc(1'b1);
        n = 0;
        while (!(res_sent == TOTAL - 1 && since_voc >= TO + 20) && n < 5000) begin cyc(1'b0); n++; end
`ifdef CONV1_CTRL_TIMEOUT_EN
        total++;
        if (first_err != TO) begin bad++; $display("FAIL wd_err_time: got %0d want %0d", first_err, TO); end
        total++;
        if ({err, busy} !== 2'b10 || done_cnt != 0) begin
            bad++; $display("FAIL wd_state: got err %b busy %b done %0d want 1 0 0", err, busy, done_cnt);
        end
`else
        total++;
        if ({err, busy} !== 2'b01 || done_cnt != 0 || first_err != -1) begin
            bad++; $display("FAIL no_wd_drain: got err %b busy %b done %0d want 0 1 0", err, busy, done_cnt);
        end
`endif
        withhold = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({err, busy} !== 2'b00) begin bad++; $display("FAIL wd_reset: got err %b busy %b want 0 0", err, busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        withhold = 0; poke_voc = 0; rnd_mp = 0; chk_ready = 0;
        clear_stats();
        test_reset();
        test_frame(1'b0, 1'b0, "full");
        test_frame(1'b1, 1'b0, "backpressure");
        test_frame(1'b0, 1'b1, "ignored");
        test_mid_reset();
        test_timeout();
        test_frame(1'b0, 1'b0, "back_to_back");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
